// File: rtl/lut_layer_pkg.sv
// ---------------------------------------------------------------------------
// lut_layer_pkg
// Shared definitions for the LUT layer engine:
//   - state_e     : engine operating mode (LOAD / RUN / DRAIN)
//   - DEF_*       : default geometry of the layer
//   - sat_inc32() : saturating 32-bit increment used by the result counter
// ---------------------------------------------------------------------------
package lut_layer_pkg;

    typedef enum logic [1:0] {
        LOAD  = 2'b00,
        RUN   = 2'b01,
        DRAIN = 2'b10
    } state_e;

    localparam int DEF_IN_BITS     = 7;
    localparam int DEF_OUT_BITS    = 2;
    localparam int DEF_NUM_NEURONS = 4;

    localparam logic [31:0] COUNT_MAX = 32'hFFFF_FFFF;

    // Counter sticks at all-ones instead of wrapping back to zero.
    function automatic logic [31:0] sat_inc32(input logic [31:0] value);
        logic [31:0] result;
        if (value == COUNT_MAX) begin
            result = value;
        end else begin
            result = value + 32'd1;
        end
        return result;
    endfunction

endpackage

// File: rtl/lut_neuron_ram.sv
// ---------------------------------------------------------------------------
// lut_neuron_ram
// Truth table of one neuron: 2^IN_BITS entries of OUT_BITS each.
// Synchronous write, asynchronous read. Contents are deliberately not reset
// so a programmed layer survives a reset or a reload.
// Ports:
//   clk   : write clock
//   we    : write strobe
//   waddr : write address
//   wdata : write value
//   raddr : lookup address
//   rdata : lookup result (combinational)
// ---------------------------------------------------------------------------
module lut_neuron_ram #(
    parameter int IN_BITS  = 7,
    parameter int OUT_BITS = 2
) (
    input  logic                clk,
    input  logic                we,
    input  logic [IN_BITS-1:0]  waddr,
    input  logic [OUT_BITS-1:0] wdata,
    input  logic [IN_BITS-1:0]  raddr,
    output logic [OUT_BITS-1:0] rdata
);

    logic [OUT_BITS-1:0] mem_r [0:(1 << IN_BITS)-1];

    // Table write port; no reset on the storage array.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_r[waddr] <= wdata;
        end
    end

    assign rdata = mem_r[raddr];

endmodule

// File: rtl/lut_layer_engine.sv
// ---------------------------------------------------------------------------
// lut_layer_engine
// A layer of NUM_NEURONS LUT neurons evaluated in parallel. Tables are
// programmed in LOAD, lookups stream through a valid/ready pipeline stage in
// RUN, and DRAIN lets the last pending result leave before reprogramming.
// Ports:
//   clk, rst_n        : clock, asynchronous active-low reset
//   s_valid/s_ready   : input handshake, s_data holds one address per neuron
//   m_valid/m_ready   : output handshake, m_data holds one result per neuron
//   cfg_we/neuron/addr/data : table write port (LOAD only)
//   cfg_done          : pulse, LOAD -> RUN
//   cfg_reload        : pulse, RUN -> DRAIN -> LOAD
//   cfg_err           : sticky illegal-write flag (cleared by reset only)
//   infer_count       : saturating count of completed output transactions
// ---------------------------------------------------------------------------
module lut_layer_engine
    import lut_layer_pkg::*;
#(
    parameter int IN_BITS     = DEF_IN_BITS,
    parameter int OUT_BITS    = DEF_OUT_BITS,
    parameter int NUM_NEURONS = DEF_NUM_NEURONS
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic                                s_valid,
    output logic                                s_ready,
    input  logic [NUM_NEURONS*IN_BITS-1:0]      s_data,
    output logic                                m_valid,
    input  logic                                m_ready,
    output logic [NUM_NEURONS*OUT_BITS-1:0]     m_data,
    input  logic                                cfg_we,
    input  logic [$clog2(NUM_NEURONS > 1 ? NUM_NEURONS : 2)-1:0] cfg_neuron,
    input  logic [IN_BITS-1:0]                  cfg_addr,
    input  logic [OUT_BITS-1:0]                 cfg_data,
    input  logic                                cfg_done,
    input  logic                                cfg_reload,
    output logic                                cfg_err,
    output logic [31:0]                         infer_count
);

    localparam int NEURON_W = $clog2(NUM_NEURONS > 1 ? NUM_NEURONS : 2);

    state_e                              state_r;
    state_e                              state_s;
    logic                                m_valid_r;
    logic [NUM_NEURONS*OUT_BITS-1:0]     m_data_r;
    logic                                cfg_err_r;
    logic [31:0]                         infer_count_r;

    logic                                s_ready_s;
    logic                                accept_s;
    logic                                complete_s;
    logic                                neuron_ok_s;
    logic                                bad_write_s;
    logic [NUM_NEURONS-1:0]              we_s;
    logic [NUM_NEURONS*OUT_BITS-1:0]     lookup_s;

    // A power-of-two neuron count makes every cfg_neuron code legal.
    generate
        if ((1 << NEURON_W) == NUM_NEURONS) begin : g_neuron_full
            assign neuron_ok_s = 1'b1;
        end else begin : g_neuron_part
            assign neuron_ok_s = (32'(cfg_neuron) < 32'(NUM_NEURONS));
        end
    endgenerate

    // One table per neuron; only the addressed neuron is written, only in LOAD.
    generate
        for (genvar n = 0; n < NUM_NEURONS; n++) begin : g_neuron
            assign we_s[n] = (state_r == LOAD) && cfg_we && neuron_ok_s &&
                             (cfg_neuron == NEURON_W'(n));

            lut_neuron_ram #(
                .IN_BITS  (IN_BITS),
                .OUT_BITS (OUT_BITS)
            ) u_ram (
                .clk   (clk),
                .we    (we_s[n]),
                .waddr (cfg_addr),
                .wdata (cfg_data),
                .raddr (s_data[n*IN_BITS +: IN_BITS]),
                .rdata (lookup_s[n*OUT_BITS +: OUT_BITS])
            );
        end
    endgenerate

    // Next-state logic; cfg_done only counts in LOAD, cfg_reload only in RUN.
    always_comb begin
        state_s = state_r;
        case (state_r)
            LOAD: begin
                if (cfg_done) begin
                    state_s = RUN;
                end else begin
                    state_s = LOAD;
                end
            end
            RUN: begin
                if (cfg_reload) begin
                    state_s = DRAIN;
                end else begin
                    state_s = RUN;
                end
            end
            DRAIN: begin
                if (!m_valid_r) begin
                    state_s = LOAD;
                end else begin
                    state_s = DRAIN;
                end
            end
            default: begin
                state_s = LOAD;
            end
        endcase
    end

    // Handshake decode: the output stage is refillable when empty or draining.
    always_comb begin
        s_ready_s   = 1'b0;
        bad_write_s = 1'b0;
        if (state_r == RUN) begin
            s_ready_s = !m_valid_r || m_ready;
        end else begin
            s_ready_s = 1'b0;
        end
        if (cfg_we && ((state_r != LOAD) || !neuron_ok_s)) begin
            bad_write_s = 1'b1;
        end else begin
            bad_write_s = 1'b0;
        end
    end

    assign accept_s   = s_valid && s_ready_s;
    assign complete_s = m_valid_r && m_ready;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= LOAD;
        end else begin
            state_r <= state_s;
        end
    end

    // Output stage: a new accept overwrites in the same cycle the old leaves.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_valid_r <= 1'b0;
            m_data_r  <= '0;
        end else if (accept_s) begin
            m_valid_r <= 1'b1;
            m_data_r  <= lookup_s;
        end else if (complete_s) begin
            m_valid_r <= 1'b0;
        end
    end

    // Sticky error flag and saturating transaction counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cfg_err_r     <= 1'b0;
            infer_count_r <= 32'd0;
        end else begin
            if (bad_write_s) begin
                cfg_err_r <= 1'b1;
            end
            if (complete_s) begin
                infer_count_r <= sat_inc32(infer_count_r);
            end
        end
    end

    assign s_ready     = s_ready_s;
    assign m_valid     = m_valid_r;
    assign m_data      = m_data_r;
    assign cfg_err     = cfg_err_r;
    assign infer_count = infer_count_r;

endmodule
